// File: rtl/layer_event_bridge.sv
// Bridges pooled output events of one conv layer into the input event FIFO of the next.
// Optional build macro LAYER_EVENT_BRIDGE_ZERO_FILTER_EN drops spike-less data events at the write side.
module layer_event_bridge #(
  parameter int BITS_PER_COORDINATE_IN  = 7,
  parameter int BITS_PER_COORDINATE_OUT = 8,
  parameter int CHANNELS                = 4,
  parameter int DEPTH                   = 16,
  parameter int COUNT_WIDTH             = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [2*BITS_PER_COORDINATE_IN+CHANNELS:0]      up_data,
  input  logic                                            up_write_enable,
  output logic                                            up_full_next,
  output logic [2*BITS_PER_COORDINATE_OUT+CHANNELS:0]     dn_data,
  output logic                                            dn_write_enable,
  input  logic                                            dn_full_next,
  output logic [COUNT_WIDTH-1:0]                          event_count,
  output logic                                            overflow,
  output logic                                            empty
);

  localparam int UW = 2*BITS_PER_COORDINATE_IN + CHANNELS + 1;
  localparam int DW = 2*BITS_PER_COORDINATE_OUT + CHANNELS + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

  logic [UW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          out_valid;
  logic          dn_full_q;

  logic [UW-1:0]                      head;
  logic                               head_ts;
  logic [BITS_PER_COORDINATE_IN-1:0]  head_x;
  logic [BITS_PER_COORDINATE_IN-1:0]  head_y;
  logic [CHANNELS-1:0]                head_sp;
  logic [BITS_PER_COORDINATE_OUT-1:0] wide_x;
  logic [BITS_PER_COORDINATE_OUT-1:0] wide_y;
  logic [DW-1:0]                      head_wide;

  logic keep;
  logic accept;
  logic drop;
  logic issue;
  logic pop;

  assign head    = mem[rd_ptr];
  assign head_ts = head[UW-1];
  assign head_x  = head[UW-2 -: BITS_PER_COORDINATE_IN];
  assign head_y  = head[UW-2-BITS_PER_COORDINATE_IN -: BITS_PER_COORDINATE_IN];
  assign head_sp = head[CHANNELS-1:0];
  assign wide_x  = BITS_PER_COORDINATE_OUT'(head_x);
  assign wide_y  = BITS_PER_COORDINATE_OUT'(head_y);
  assign head_wide = {head_ts, wide_x, wide_y, head_sp};

`ifdef LAYER_EVENT_BRIDGE_ZERO_FILTER_EN
  assign keep = up_data[UW-1] | (|up_data[CHANNELS-1:0]);
`else
  assign keep = 1'b1;
`endif

  assign accept = up_write_enable & keep & (count < DEPTH_C);
  assign drop   = up_write_enable & keep & (count == DEPTH_C);

  // Issue is qualified by dn_full_next as sampled at the previous edge.
  assign issue = out_valid & ~dn_full_q;
  assign pop   = (count != '0) & (~out_valid | issue);

  assign dn_write_enable = issue;
  assign up_full_next    = (count >= DEPTH_M1_C);
  assign empty           = (count == '0) & ~out_valid;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= up_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      dn_data     <= '0;
      dn_full_q   <= 1'b0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      dn_full_q <= dn_full_next;
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (drop) overflow <= 1'b1;

      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        dn_data   <= head_wide;
        out_valid <= 1'b1;
      end else if (issue) begin
        out_valid <= 1'b0;
      end

      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (issue) begin
        if (dn_data[DW-1])
          event_count <= '0;
        else if (event_count != '1)
          event_count <= event_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
